// File: rtl/restoring_divider16_pkg.sv
// Shared definitions for the restoring divider: FSM encoding, default width
// and the iteration-counter sizing helper.
package restoring_divider16_pkg;

   localparam int unsigned DefWidth = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Counter must hold the value Width itself, not just Width-1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/restoring_divider16_trial_subtractor.sv
// (Width+1)-bit trial subtraction a - b as a full-adder ripple of a + ~b + 1.
// Only the low Width difference bits are needed by the divider; borrow = ~carry-out.
module restoring_divider16_trial_subtractor #(
   parameter int unsigned Width = 16
) (
   input  logic [Width:0]   a_i,
   input  logic [Width:0]   b_i,
   output logic [Width-1:0] diff_o,
   output logic             borrow_o
);

   logic [Width:0]   b_n;
   logic [Width+1:0] carry;

   assign b_n      = ~b_i;
   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= Width; i++) begin : g_fa
      if (i < Width) begin : g_sum
         assign diff_o[i] = a_i[i] ^ b_n[i] ^ carry[i];
      end
      assign carry[i+1] = (a_i[i] & b_n[i]) | (carry[i] & (a_i[i] ^ b_n[i]));
   end

   assign borrow_o = ~carry[Width+1];

endmodule

// File: rtl/restoring_divider16.sv
// Sequential unsigned restoring divider: one shift-and-subtract step per clock,
// start/done handshake, results held until the next completed operation.
module restoring_divider16
   import restoring_divider16_pkg::*;
#(
   parameter int unsigned Width = DefWidth
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [Width-1:0] dividend_i,
   input  logic [Width-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Width-1:0] quotient_o,
   output logic [Width-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int unsigned CntW = cnt_width(Width);

   state_e            state_q, state_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [Width-1:0]  rem_q, rem_d;
   logic [Width-1:0]  q_q, q_d;
   logic [Width-1:0]  divisor_q, divisor_d;
   logic [Width-1:0]  quot_q, quot_d;
   logic [Width-1:0]  res_rem_q, res_rem_d;
   logic              dbz_q, dbz_d;

   logic              accept;
   logic              last_step;
   logic [Width:0]    shifted;
   logic [Width-1:0]  trial_diff;
   logic              trial_borrow;
   logic [Width-1:0]  rem_step;
   logic [Width-1:0]  q_step;

   assign accept    = start_i && (state_q != StRun);
   assign last_step = (count_q == CntW'(1));
   assign shifted   = {rem_q, q_q[Width-1]};

   restoring_divider16_trial_subtractor #(
      .Width(Width)
   ) u_trial_sub (
      .a_i     (shifted),
      .b_i     ({1'b0, divisor_q}),
      .diff_o  (trial_diff),
      .borrow_o(trial_borrow)
   );

   // On borrow the trial is discarded, which restores the shifted partial remainder.
   assign rem_step = trial_borrow ? shifted[Width-1:0] : trial_diff;
   assign q_step   = {q_q[Width-2:0], ~trial_borrow};

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = (divisor_i == '0) ? StDone : StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (last_step) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      busy_o        = (state_q == StRun);
      done_o        = (state_q == StDone);
      quotient_o    = quot_q;
      remainder_o   = res_rem_q;
      div_by_zero_o = dbz_q;
   end

   // Datapath next-state
   always_comb begin
      count_d   = count_q;
      rem_d     = rem_q;
      q_d       = q_q;
      divisor_d = divisor_q;
      quot_d    = quot_q;
      res_rem_d = res_rem_q;
      dbz_d     = dbz_q;
      if (accept) begin
         if (divisor_i != '0) begin
            divisor_d = divisor_i;
            rem_d     = '0;
            q_d       = dividend_i;
            count_d   = CntW'(Width);
         end else begin
            quot_d    = '1;
            res_rem_d = dividend_i;
            dbz_d     = 1'b1;
         end
      end else if (state_q == StRun) begin
         rem_d   = rem_step;
         q_d     = q_step;
         count_d = count_q - CntW'(1);
         // Results are published only on DONE entry so they stay stable while running.
         if (last_step) begin
            quot_d    = q_step;
            res_rem_d = rem_step;
            dbz_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q   <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         divisor_q <= '0;
         quot_q    <= '0;
         res_rem_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         rem_q     <= rem_d;
         q_q       <= q_d;
         divisor_q <= divisor_d;
         quot_q    <= quot_d;
         res_rem_q <= res_rem_d;
         dbz_q     <= dbz_d;
      end
   end

endmodule
